// File: rtl/reg_multiply_unit_if.sv
// Bundle of the multiply unit's command/status signals and its register file port.
// The master side issues commands and serves register reads; the slave side is the unit.
interface reg_multiply_unit_if #(
    parameter int WIDTH       = 16,
    parameter int INDEX_WIDTH = 2
);
    logic                   start;
    logic [INDEX_WIDTH-1:0] src_a;
    logic [INDEX_WIDTH-1:0] src_b;
    logic [INDEX_WIDTH-1:0] dst;
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic [INDEX_WIDTH-1:0] rf_read_index;
    logic [WIDTH-1:0]       rf_read_data;
    logic [INDEX_WIDTH-1:0] rf_write_index;
    logic [WIDTH-1:0]       rf_write_data;
    logic                   rf_write_enable;

    // Handshake: start is a request honoured only while busy is low; a request
    // made while busy is dropped. done marks the single cycle in which the
    // register file write is presented (rf_write_enable high), committing on
    // the following rising edge.
    modport master (
        output start, src_a, src_b, dst, rf_read_data,
        input  busy, done, overflow, rf_read_index,
               rf_write_index, rf_write_data, rf_write_enable
    );

    modport slave (
        input  start, src_a, src_b, dst, rf_read_data,
        output busy, done, overflow, rf_read_index,
               rf_write_index, rf_write_data, rf_write_enable
    );
endinterface

// File: rtl/reg_multiply_unit.sv
// Multi-cycle shift-add multiplier that fetches two operands from the register
// file through its single read port and writes the low half of the product back.
module reg_multiply_unit #(
    parameter int WIDTH       = 16,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_multiply_unit_if.slave   bus,
    output logic [2:0]           debug_state
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        MULT    = 3'd3,
        WRITE   = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [INDEX_WIDTH-1:0] src_a_q;
    logic [INDEX_WIDTH-1:0] src_b_q;
    logic [INDEX_WIDTH-1:0] dst_q;
    logic [2*WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [CW-1:0]          cnt_q;
    logic                   ovf_q;
    logic [2*WIDTH-1:0]     step_acc;
    logic                   last_step;

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign step_acc  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH_A;
            FETCH_A: state_d = FETCH_B;
            FETCH_B: state_d = MULT;
            MULT:    if (last_step) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The multiplicand is kept pre-shifted so each MULT step is a plain add.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        src_a_q <= bus.src_a;
                        src_b_q <= bus.src_b;
                        dst_q   <= bus.dst;
                    end
                end
                FETCH_A: begin
                    mcand_q <= {{WIDTH{1'b0}}, bus.rf_read_data};
                end
                FETCH_B: begin
                    mplier_q <= bus.rf_read_data;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                MULT: begin
                    acc_q    <= step_acc;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_step) begin
                        ovf_q <= |step_acc[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.busy            = (state_q != IDLE);
        bus.done            = (state_q == WRITE);
        bus.overflow        = ovf_q;
        bus.rf_read_index   = '0;
        bus.rf_write_index  = '0;
        bus.rf_write_data   = '0;
        bus.rf_write_enable = 1'b0;
        case (state_q)
            FETCH_A: bus.rf_read_index = src_a_q;
            FETCH_B: bus.rf_read_index = src_b_q;
            WRITE: begin
                bus.rf_write_enable = 1'b1;
                bus.rf_write_index  = dst_q;
                bus.rf_write_data   = acc_q[WIDTH-1:0];
            end
            default: begin
            end
        endcase
    end

    assign debug_state = state_q;
endmodule

// File: doc/reg_multiply_unit.md
Name: reg_multiply_unit

Overview:
- Multi-cycle multiply sequencer sitting beside the 4-entry x 16-bit register_file.
- Drives the register file's single read port (read_index_a / read_data_a) to fetch two operands.
- Computes their product with a shift-add datapath.
- Writes the low half of the product back through the register file's write port (write_index / write_data / write_enable).
- Consumes register file read data and produces its write traffic; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand, register and result width; must match register_file data width.
- INDEX_WIDTH, 2, register index width; must match register_file index width.

Ports:
- clk  input  1  rising-edge clock, shared with register_file.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- src_a  input  INDEX_WIDTH  index of operand A; captured on start acceptance.
- src_b  input  INDEX_WIDTH  index of operand B; captured on start acceptance.
- dst  input  INDEX_WIDTH  destination index; captured on start acceptance.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, high during WRITE.
- overflow  output  1  high when product bits [2*WIDTH-1:WIDTH] of the last operation were nonzero.
- rf_read_index  output  INDEX_WIDTH  to register_file read_index_a.
- rf_read_data  input  WIDTH  from register_file read_data_a; combinational read.
- rf_write_index  output  INDEX_WIDTH  to register_file write_index.
- rf_write_data  output  WIDTH  to register_file write_data.
- rf_write_enable  output  1  to register_file write_enable; commits on rising edge.

Behaviour:
- Reset asserted (reset==0, async):
  - state=IDLE; busy, done, overflow, rf_write_enable = 0.
  - rf_read_index, rf_write_index, rf_write_data = 0.
  - Captured indices, operands, accumulator and counter cleared.
- FSM states: IDLE -> FETCH_A -> FETCH_B -> MULT -> WRITE -> IDLE.
- IDLE:
  - start==1 at a rising edge (edge E0): capture src_a, src_b, dst; go to FETCH_A.
  - start==0: stay in IDLE.
- FETCH_A: rf_read_index=src_a. At E1, latch rf_read_data as multiplicand; go to FETCH_B.
- FETCH_B: rf_read_index=src_b. At E2, latch rf_read_data as multiplier; clear 2*WIDTH accumulator and counter; go to MULT.
- MULT: one step per edge, E3..E(2+WIDTH), i.e. E3..E18 at WIDTH=16.
  - If multiplier LSB==1, accumulator += multiplicand (zero-extended to 2*WIDTH, shifted left by step count).
  - Then multiplier >>= 1 and counter += 1.
  - When counter reaches WIDTH-1 at an edge, go to WRITE.
  - Operands are unsigned; no early termination on a zero multiplier, so latency is fixed.
- WRITE:
  - rf_write_enable=1, rf_write_index=dst, rf_write_data=accumulator[WIDTH-1:0], done=1.
  - overflow register updated at entry to WRITE.
  - Write commits at E(3+WIDTH) (E19); return to IDLE.
- Latency:
  - busy rises the cycle after E0 and stays high for WIDTH+3 cycles (19 at WIDTH=16).
  - Destination register holds the result after E19.
- rf_read_index holds src_a/src_b in fetch states and 0 in all other states.
- rf_write_enable is 0 in all states except WRITE; no spurious writes.
- start while busy is ignored; it is neither queued nor re-captured.
- src_a==src_b is legal: the same register is read twice, giving its square.
- dst equal to a source is legal: operands are latched before the write, so no hazard.
- overflow holds its value until the next WRITE; it is not cleared by start.
- Reset mid-operation (any state) aborts immediately: no write is issued and all register file contents are untouched.
- Register file preload is the bench's job: the bench muxes the register_file write port to its own driver while busy==0.

Test Plan:
- Reset -> reset=0 for 2 cycles: busy=0, done=0, overflow=0, rf_write_enable=0, rf_read_index=0, rf_write_data=0.
- Basic multiply -> preload r1=3, r2=7; start with src_a=1, src_b=2, dst=3: busy high for 19 cycles; done and rf_write_enable high exactly in cycle 19; r3==21; overflow=0; r1, r2 unchanged.
- Overflow and self-overwrite -> r0=0x0100, r1=0x0100; start with src_a=0, src_b=1, dst=0: r0==0x0000, overflow=1. Then r2=0xFFFF squared into r2: r2==0x0001, overflow=1.
- Zero and identity -> r1=0, r2=0xABCD: 0*0xABCD gives 0 with overflow=0. Then r3=1 and r2*r3 into r1 gives r1==0xABCD, overflow=0, same 19-cycle latency.
- start while busy -> pulse start with dst=2 at MULT step 5 of a 3*7 into r3: result is only r3==21; r2 unchanged; exactly one rf_write_enable pulse; busy returns 0 after cycle 19.
- Reset mid-MULT -> assert reset at step 8 of 5*5 into r0 (r0=0x1234 beforehand): busy and rf_write_enable drop immediately; r0 stays 0x1234. Next start with 2*2 into r0 gives r0==4.
